// File: rtl/line_rx.sv
`default_nettype none
// ============================================================================
//  Module      : line_rx
//  Description : 8N1 serial line receiver. Deserialises bytes from rx with
//                mid-bit sampling and collects them into a DEPTH-byte line
//                buffer until LF. The completed line is held for the host
//                behind a registered read port until line_ack.
//                Optional build macro LINE_RX_CR_STRIP_EN: drop 0x0D bytes
//                while filling a line.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_rx #(
    parameter int CLK_DIV = 104,
    parameter int DEPTH   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       line_valid,
    output logic [5:0] line_len,
    input  logic       line_ack,
    output logic       overflow,
    output logic       frame_err
);

    localparam int              c_CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CW-1:0] c_BIT_FULL = c_CW'(CLK_DIV - 1);
    localparam logic [c_CW-1:0] c_BIT_HALF = c_CW'(CLK_DIV / 2 - 1);
    localparam logic [c_CW-1:0] c_ONE      = c_CW'(1);
    localparam logic [5:0]      c_DEPTH    = 6'(DEPTH);
    localparam logic [7:0]      c_LF       = 8'h0A;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    typedef enum logic [0:0] {
        L_FILL = 1'b0,
        L_HOLD = 1'b1
    } line_state_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [1:0]      r_sync;
    logic            w_rxs;

    rx_state_t       r_rx_state, w_rx_next;
    logic [c_CW-1:0] r_cnt, w_cnt_next;
    logic [2:0]      r_bit_idx, w_idx_next;
    logic [7:0]      r_shift, w_shift_next;
    logic            w_byte_ok, r_byte_ok;
    logic            w_frame_err, r_frame_err;
    logic            w_cnt_zero;

    line_state_t     r_line_state, w_line_next;
    logic [5:0]      r_ptr, w_ptr_next;
    logic [5:0]      r_line_len, w_len_next;
    logic            r_line_valid, w_valid_next;
    logic            r_overflow, w_ovf_next;
    logic            w_wr_en;
    logic            w_is_cr;

    logic [7:0]      r_buf [DEPTH];
    logic [7:0]      r_rd_data;

`ifdef LINE_RX_CR_STRIP_EN
    localparam logic [7:0] c_CR = 8'h0D;
    assign w_is_cr = (r_shift == c_CR);
`else
    assign w_is_cr = 1'b0;
`endif

    // Two-flop synchroniser; idle-high so reset value is 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= 2'b11;
        else     r_sync <= {r_sync[0], rx};
    end

    assign w_rxs      = r_sync[1];
    assign w_cnt_zero = (r_cnt == '0);

    // Bit FSM state and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state  <= RX_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_byte_ok   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_state  <= w_rx_next;
            r_cnt       <= w_cnt_next;
            r_bit_idx   <= w_idx_next;
            r_shift     <= w_shift_next;
            r_byte_ok   <= w_byte_ok;
            r_frame_err <= w_frame_err;
        end
    end

    // Bit FSM next state: half-bit to centre of start, then full bits
    always_comb begin
        w_rx_next    = r_rx_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_byte_ok    = 1'b0;
        w_frame_err  = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (!w_rxs) begin
                    w_cnt_next = c_BIT_HALF;
                    w_rx_next  = RX_START;
                end
            end
            RX_START: begin
                if (w_cnt_zero) begin
                    if (w_rxs) begin
                        w_rx_next = RX_IDLE;
                    end else begin
                        w_cnt_next = c_BIT_FULL;
                        w_idx_next = 3'd0;
                        w_rx_next  = RX_DATA;
                    end
                end else begin
                    w_cnt_next = r_cnt - c_ONE;
                end
            end
            RX_DATA: begin
                if (w_cnt_zero) begin
                    w_shift_next = {w_rxs, r_shift[7:1]};
                    w_cnt_next   = c_BIT_FULL;
                    if (r_bit_idx == 3'd7) w_rx_next = RX_STOP;
                    else                   w_idx_next = r_bit_idx + 3'd1;
                end else begin
                    w_cnt_next = r_cnt - c_ONE;
                end
            end
            RX_STOP: begin
                if (w_cnt_zero) begin
                    if (w_rxs) begin
                        w_byte_ok = 1'b1;
                        w_rx_next = RX_IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_rx_next   = RX_BREAK;
                    end
                end else begin
                    w_cnt_next = r_cnt - c_ONE;
                end
            end
            RX_BREAK: begin
                if (w_rxs) w_rx_next = RX_IDLE;
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    // Line FSM state and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line_state <= L_FILL;
            r_ptr        <= 6'd0;
            r_line_len   <= 6'd0;
            r_line_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_line_state <= w_line_next;
            r_ptr        <= w_ptr_next;
            r_line_len   <= w_len_next;
            r_line_valid <= w_valid_next;
            r_overflow   <= w_ovf_next;
        end
    end

    // Line FSM next state: fill until LF, hold until ack; pointer saturates
    always_comb begin
        w_line_next  = r_line_state;
        w_ptr_next   = r_ptr;
        w_len_next   = r_line_len;
        w_valid_next = r_line_valid;
        w_ovf_next   = r_overflow;
        w_wr_en      = 1'b0;
        case (r_line_state)
            L_FILL: begin
                if (r_byte_ok) begin
                    if (r_shift == c_LF) begin
                        w_len_next   = r_ptr;
                        w_valid_next = 1'b1;
                        w_line_next  = L_HOLD;
                    end else if (w_is_cr) begin
                        w_ptr_next = r_ptr;
                    end else if (r_ptr < c_DEPTH) begin
                        w_wr_en    = 1'b1;
                        w_ptr_next = r_ptr + 6'd1;
                    end else begin
                        w_ovf_next = 1'b1;
                    end
                end
            end
            L_HOLD: begin
                if (line_ack) begin
                    // A byte landing with the ack is lost and flags the new line
                    w_valid_next = 1'b0;
                    w_ovf_next   = r_byte_ok;
                    w_ptr_next   = 6'd0;
                    w_line_next  = L_FILL;
                end else if (r_byte_ok) begin
                    w_ovf_next = 1'b1;
                end
            end
            default: w_line_next = L_FILL;
        endcase
    end

    // Line buffer storage; contents are only meaningful below the pointer
    always_ff @(posedge clk) begin
        if (w_wr_en) r_buf[r_ptr[4:0]] <= r_shift;
    end

    // Registered read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rd_data <= 8'h00;
        else     r_rd_data <= r_buf[rd_addr];
    end

    assign rd_data    = r_rd_data;
    assign line_valid = r_line_valid;
    assign line_len   = r_line_len;
    assign overflow   = r_overflow;
    assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_line_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_rx
//  Description : Self-checking bench for line_rx: directed scenarios plus
//                random lines compared against a queue-based line model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_rx;

    localparam int CLK_DIV = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic [4:0] rd_addr = 5'd0;
    logic       line_ack = 1'b0;
    logic [7:0] rd_data;
    logic       line_valid;
    logic [5:0] line_len;
    logic       overflow;
    logic       frame_err;

    int total = 0;
    int bad   = 0;
    int fe_seen = 0;

    // Reference line model
    logic [7:0] m_q[$];
    bit         m_ovf  = 1'b0;
    bit         m_hold = 1'b0;

    line_rx #(.CLK_DIV(CLK_DIV), .DEPTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .line_valid (line_valid),
        .line_len   (line_len),
        .line_ack   (line_ack),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Running count of cycles with frame_err high
    always @(negedge clk) if (frame_err) fe_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_byte(input logic [7:0] b);
        if (m_hold) begin
            m_ovf = 1'b1;
        end else if (b == 8'h0A) begin
            m_hold = 1'b1;
        end else begin
`ifdef LINE_RX_CR_STRIP_EN
            if (b == 8'h0D) return;
`endif
            if (m_q.size() < 32) m_q.push_back(b);
            else                 m_ovf = 1'b1;
        end
    endfunction

    function automatic void model_clear();
        m_q.delete();
        m_ovf  = 1'b0;
        m_hold = 1'b0;
    endfunction

    // One 8N1 frame, driven on negedges; idle gap after a good stop bit
    task automatic send_raw(input logic [7:0] b, input bit stopv);
        rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx = stopv;
        repeat (CLK_DIV) @(negedge clk);
        if (stopv) repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_raw(b, 1'b1);
        model_byte(b);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(8'(s[i]));
    endtask

    task automatic check_line(input string tag);
        int n = 0;
        while (!line_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(line_valid), 32'(m_hold));
        check({tag, "_len"}, 32'(line_len), 32'(m_q.size()));
        check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        for (int i = 0; i < m_q.size(); i++) begin
            rd_addr = 5'(i);
            @(negedge clk);
            @(negedge clk);
            check($sformatf("%s_buf%0d", tag, i), 32'(rd_data), 32'(m_q[i]));
        end
    endtask

    task automatic do_ack(input string tag);
        line_ack = 1'b1;
        @(negedge clk);
        line_ack = 1'b0;
        check({tag, "_ackvalid"}, 32'(line_valid), 32'd0);
        model_clear();
    endtask

    initial begin
        int fe0;
        int len;
        logic [7:0] b;

        repeat (3) @(negedge clk);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_valid", 32'(line_valid), 32'd0);
        check("rst_len", 32'(line_len), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic line
        send_str("AB\n");
        check_line("basic");
        do_ack("basic");

        // CR handling (model follows the build macro)
        send_str("A\r\n");
        check_line("cr");
        do_ack("cr");

        // Overflow: 33 bytes then LF
        for (int i = 0; i < 33; i++) send_byte(8'(8'h30 + i));
        send_byte(8'h0A);
        check_line("ovf");
        do_ack("ovf");

        // Framing error: bad stop, line held low two bit times, then released
        fe0 = fe_seen;
        send_raw(8'h55, 1'b0);
        repeat (2 * CLK_DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clk);
        check("ferr_pulse", 32'(fe_seen - fe0), 32'd1);
        send_byte(8'h0A);
        check_line("ferr");
        do_ack("ferr");

        // False start glitch, then a line, then a byte during hold
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clk);
        send_str("Q\n");
        check_line("glitch");
        send_byte(8'h58);
        check_line("hold");
        do_ack("hold");

        // Reset mid-byte after two stored bytes
        send_str("12");
        rx = 1'b0;
        repeat (3 * CLK_DIV) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        check("mrst_rd_data", 32'(rd_data), 32'd0);
        check("mrst_valid", 32'(line_valid), 32'd0);
        check("mrst_len", 32'(line_len), 32'd0);
        check("mrst_ovf", 32'(overflow), 32'd0);
        check("mrst_ferr", 32'(frame_err), 32'd0);
        rst = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        send_str("Z\n");
        check_line("mrst");
        do_ack("mrst");

        // Random lines, some with a byte arriving while held
        for (int l = 0; l < 12; l++) begin
            len = int'($urandom_range(0, 36));
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h0A) b = 8'h0B;
                if ($urandom_range(0, 15) == 0) b = 8'h0D;
                send_byte(b);
            end
            send_byte(8'h0A);
            check_line($sformatf("rnd%0d", l));
            if ($urandom_range(0, 2) == 0) begin
                send_byte(8'($urandom_range(0, 255)));
                check_line($sformatf("rndh%0d", l));
            end
            do_ack($sformatf("rnd%0d", l));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/line_rx.md
# line_rx

Serial line receiver for the command link, sitting at the PC-to-FPGA end of the 8N1 UART. It deserialises bytes from `rx` with mid-bit sampling and assembles them into a 32-byte line buffer until LF (0x0A). It then presents the completed line to the host logic through a registered read port and holds it until acknowledged. It mirrors the ROM-driven transmit path: that path emits LF-terminated strings, and this block collects LF-terminated strings.

## Interface
- `CLK_DIV`, 104: clock cycles per bit (12 MHz / 115200); legal range ≥ 4.
- `DEPTH`, 32: line buffer bytes; fixed power of two, address width 5.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rx` in 1: serial input, idle high, asynchronous to `clk`.
- `rd_addr` in 5: buffer read address.
- `rd_data` out 8: buffer byte at `rd_addr`, registered.
- `line_valid` out 1: completed line held; level.
- `line_len` out 6: byte count of held line, 0..32.
- `line_ack` in 1: single-cycle release of held line.
- `overflow` out 1: bytes were dropped from the current line.
- `frame_err` out 1: one-cycle pulse on a bad stop bit.

## Operation
- Reset: `rd_data`=0, `line_valid`=0, `line_len`=0, `overflow`=0, `frame_err`=0, write pointer 0, both states IDLE/FILL. Synchroniser flops reset to 1.
- `rx` passes through a 2-FF synchroniser; `rxs` below is the synchronised value.

Bit FSM (RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK):
- RX_IDLE: on `rxs`=0, load counter with CLK_DIV/2−1 and go to RX_START.
- RX_START: at counter 0, if `rxs`=1 treat it as a false start and go to RX_IDLE. Otherwise reload CLK_DIV−1 and go to RX_DATA.
- RX_DATA: sample at each counter expiry, LSB first, 8 bits, then go to RX_STOP.
- RX_STOP: at counter expiry, if `rxs`=1, pulse internal `byte_ok` for 1 cycle and go to RX_IDLE. If `rxs`=0, pulse `frame_err`, discard the byte, and go to RX_BREAK.
- RX_BREAK: wait for `rxs`=1, then go to RX_IDLE.

Line FSM (L_FILL, L_HOLD), acting on `byte_ok`:
- L_FILL, byte = 0x0A: `line_len` ← pointer, `line_valid` ← 1, go to L_HOLD. The LF itself is not stored.
- L_FILL, other byte, pointer < 32: write `buf[ptr]`, increment pointer.
- L_FILL, other byte, pointer = 32: drop the byte and set `overflow`. The pointer saturates at 32 and never wraps.
- L_HOLD, any byte: dropped and `overflow` set; the buffer is unchanged.
- L_HOLD, `line_ack`: `line_valid` ← 0, `overflow` ← 0, pointer ← 0, go to L_FILL. `line_len` keeps its last value.
- `line_ack` in L_FILL is ignored.
- `line_ack` and `byte_ok` in the same cycle in L_HOLD: the ack is processed, the byte is dropped, and `overflow` is set to 1 for the new line.
- An LF with pointer 0 is legal: `line_valid` asserts with `line_len`=0.
- Reset mid-frame or mid-line aborts everything; the partial line is lost.

## Timing
- `byte_ok` fires at the middle of the stop bit, (9.5·CLK_DIV + 2..3) cycles after the `rx` falling edge.
- The buffer write, or the `line_valid`/`line_len` update, happens on the clock edge after `byte_ok`.
- `rd_data` is `buf[rd_addr]` one cycle after `rd_addr` is presented. It is readable at all times and stable in L_HOLD.
- `frame_err` is exactly 1 cycle wide.
- Bit timing is measured from the synchronised edge. Receiver tolerance is ±4% baud mismatch at CLK_DIV=104.

## Configuration
- `LINE_RX_CR_STRIP_EN` defined: in L_FILL, a 0x0D byte is discarded. It does not increment the pointer and does not count toward overflow.
- Macro undefined: 0x0D is stored like any other byte.

## Test plan
- Basic line: CLK_DIV=8, send 0x41 0x42 0x0A. Required: `line_valid`=1, `line_len`=2, rd 0→0x41, rd 1→0x42, `overflow`=0. Then `line_ack`: `line_valid`=0 next cycle.
- CR handling: send 0x41 0x0D 0x0A. With `LINE_RX_CR_STRIP_EN`: `line_len`=1. Without it: `line_len`=2 and `buf[1]`=0x0D.
- Overflow: send 33 bytes 0x30..0x50, then 0x0A. Required: `line_len`=32, `overflow`=1, `buf[31]`=0x4F, `buf[0]`=0x30.
- Framing error: send 0x55 with stop bit 0, hold `rx` low 2 bit times, then release. Required: one-cycle `frame_err`, pointer unchanged. A following 0x0A yields `line_len`=0.
- False start and hold: a 2-cycle low glitch on `rx` produces no byte. Sending 0x58 while `line_valid`=1 leaves the buffer unchanged and sets `overflow`=1.
- Reset: assert `rst` mid-byte after 2 stored bytes. Required: all outputs 0. The next line "Z\n" gives `line_len`=1 and `buf[0]`=0x5A.
